// File: rtl/grad_inlet_pkg.sv
// Shared state encoding and default sizing for the gradient generator inlet sequencer.
package grad_inlet_pkg;

  localparam int unsigned DEF_PERIOD_W     = 16;
  localparam int unsigned DEF_COUNT_W      = 24;
  localparam int unsigned DEF_VALVE_SETTLE = 1000;
  localparam int unsigned DEF_PRIME_STEPS  = 256;
  localparam int unsigned DEF_PRIME_PERIOD = 64;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    PRIME,
    RUN,
    CLOSE
  } state_t;

endpackage

// File: rtl/step_divider.sv
// Programmable step divider: loads period-1 on load, pulses when the count hits zero, then reloads.
module step_divider #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         pulse
);

  logic [W-1:0] cnt;

  assign pulse = en && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || pulse) begin
      cnt <= period - W'(1);
    end else if (en) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/gradient_inlet_sequencer.sv
// Inlet pump/valve sequencer: open -> prime -> run -> close per accepted command.
// GRAD_INLET_BUBBLE_ABORT_EN adds bubble_det inputs that abort the run and set a sticky fault.
module gradient_inlet_sequencer
  import grad_inlet_pkg::*;
#(
  parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
  parameter int unsigned COUNT_W      = DEF_COUNT_W,
  parameter int unsigned VALVE_SETTLE = DEF_VALVE_SETTLE,
  parameter int unsigned PRIME_STEPS  = DEF_PRIME_STEPS,
  parameter int unsigned PRIME_PERIOD = DEF_PRIME_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PERIOD_W-1:0] cmd_period_a,
  input  logic [PERIOD_W-1:0] cmd_period_b,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic                abort,
  output logic                valve_a,
  output logic                valve_b,
  output logic                step_a,
  output logic                step_b,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [COUNT_W-1:0]  steps_done,
  output logic                fault
`ifdef GRAD_INLET_BUBBLE_ABORT_EN
  ,
  input  logic [1:0]          bubble_det
`endif
);

  localparam int unsigned TIMER_W = $clog2(VALVE_SETTLE + 1);

  state_t              state, state_next;
  logic [PERIOD_W-1:0] period_a_q, period_b_q, div_period_a, div_period_b;
  logic [COUNT_W-1:0]  steps_q, prime_cnt;
  logic [TIMER_W-1:0]  timer;
  logic en_a, en_b, accept, entry, abort_evt, bubble_hit;
  logic div_en_a, div_en_b, pulse_a, pulse_b, ref_pulse, flowing;

  assign en_a      = (period_a_q != '0);
  assign en_b      = (period_b_q != '0);
  assign accept    = cmd_valid && (state == IDLE);
  assign entry     = (state_next != state);
  assign ref_pulse = en_a ? pulse_a : pulse_b;
  assign flowing   = (state == OPEN) || (state == PRIME) || (state == RUN);
  assign abort_evt = bubble_hit || (abort && flowing);

`ifdef GRAD_INLET_BUBBLE_ABORT_EN
  logic [1:0] bubble_s1, bubble_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_s1 <= '0;
      bubble_s2 <= '0;
      fault     <= 1'b0;
    end else begin
      bubble_s1 <= bubble_det;
      bubble_s2 <= bubble_s1;
      if (accept)          fault <= 1'b0;
      else if (bubble_hit) fault <= 1'b1;
    end
  end

  assign bubble_hit = ((state == PRIME) || (state == RUN)) &&
                      ((bubble_s2[0] && en_a) || (bubble_s2[1] && en_b));
`else
  assign bubble_hit = 1'b0;
  assign fault      = 1'b0;
`endif

  // Dividers reload on every state change, so the period must follow the state being entered.
  assign div_period_a = (state_next == PRIME) ? PERIOD_W'(PRIME_PERIOD) : period_a_q;
  assign div_period_b = (state_next == PRIME) ? PERIOD_W'(PRIME_PERIOD) : period_b_q;
  assign div_en_a     = en_a && ((state == PRIME) || ((state == RUN) && (steps_q != '0)));
  assign div_en_b     = en_b && ((state == PRIME) || ((state == RUN) && (steps_q != '0)));

  step_divider #(.W(PERIOD_W)) u_div_a (
    .clk(clk), .rst(rst), .load(entry), .en(div_en_a), .period(div_period_a), .pulse(pulse_a)
  );

  step_divider #(.W(PERIOD_W)) u_div_b (
    .clk(clk), .rst(rst), .load(entry), .en(div_en_b), .period(div_period_b), .pulse(pulse_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (accept && ((cmd_period_a != '0) || (cmd_period_b != '0))) state_next = OPEN;
      OPEN:
        if (abort_evt)          state_next = CLOSE;
        else if (timer == '0)   state_next = (PRIME_STEPS == 0) ? RUN : PRIME;
      PRIME:
        if (abort_evt)          state_next = CLOSE;
        else if (ref_pulse && (prime_cnt == COUNT_W'(PRIME_STEPS - 1))) state_next = RUN;
      RUN:
        if (abort_evt || (steps_q == '0)) state_next = CLOSE;
        else if (ref_pulse && (steps_done == steps_q - COUNT_W'(1))) state_next = CLOSE;
      CLOSE: if (timer == '0)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    valve_a   = flowing && en_a;
    valve_b   = flowing && en_b;
    step_a    = pulse_a;
    step_b    = pulse_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_a_q <= '0;
      period_b_q <= '0;
      steps_q    <= '0;
      steps_done <= '0;
      prime_cnt  <= '0;
      timer      <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done <= (state == CLOSE) && (timer == '0);
      if (accept) begin
        period_a_q <= cmd_period_a;
        period_b_q <= cmd_period_b;
        steps_q    <= cmd_steps;
        steps_done <= '0;
        aborted    <= 1'b0;
        done       <= (cmd_period_a == '0) && (cmd_period_b == '0);
      end
      if ((abort && busy) || bubble_hit) aborted <= 1'b1;
      if (entry)              timer <= TIMER_W'(VALVE_SETTLE - 1);
      else if (timer != '0)   timer <= timer - TIMER_W'(1);
      if (entry)              prime_cnt <= '0;
      else if ((state == PRIME) && ref_pulse) prime_cnt <= prime_cnt + COUNT_W'(1);
      if ((state == RUN) && ref_pulse && (steps_done != steps_q))
        steps_done <= steps_done + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gradient_inlet_sequencer.sv
// Bench for gradient_inlet_sequencer: per-cycle output traces predicted from the sequencing rules.
module tb_gradient_inlet_sequencer;

  localparam int PW = 16;
  localparam int CW = 24;
  localparam int S  = 4;
  localparam int PS = 2;
  localparam int PP = 2;
  localparam int INF = 1 << 30;

  typedef struct packed {
    logic ready, busy, va, vb, sa, sb, done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PW-1:0] cmd_period_a = '0;
  logic [PW-1:0] cmd_period_b = '0;
  logic [CW-1:0] cmd_steps = '0;
  logic          abort = 1'b0;
  logic          valve_a, valve_b, step_a, step_b, busy, done, aborted, fault;
  logic [CW-1:0] steps_done;
`ifdef GRAD_INLET_BUBBLE_ABORT_EN
  logic [1:0]    bubble_det = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gradient_inlet_sequencer #(
    .PERIOD_W(PW), .COUNT_W(CW), .VALVE_SETTLE(S), .PRIME_STEPS(PS), .PRIME_PERIOD(PP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period_a(cmd_period_a), .cmd_period_b(cmd_period_b), .cmd_steps(cmd_steps),
    .abort(abort), .valve_a(valve_a), .valve_b(valve_b), .step_a(step_a), .step_b(step_b),
    .busy(busy), .done(done), .aborted(aborted), .steps_done(steps_done), .fault(fault)
`ifdef GRAD_INLET_BUBBLE_ABORT_EN
    , .bubble_det(bubble_det)
`endif
  );

  function automatic obs_t mk(input bit r, b, va, vb, sa, sb, d);
    return {r, b, va, vb, sa, sb, d};
  endfunction

  function automatic obs_t sample();
    return {cmd_ready, busy, valve_a, valve_b, step_a, step_b, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic run_cmd(input string name, input int pa, input int pb, input int steps,
                         input int abort_at, input int bub_at, input logic [1:0] bub_val);
    obs_t act[$];
    obs_t trace[$];
    bit   prf[$];
    bit   reff[$];
    bit   ea, eb, p, fault_e, aborted_e;
    int   pr, bi, a, n, steps_e;
    ea = (pa != 0);
    eb = (pb != 0);
    steps_e = 0;
    fault_e = 0;
    aborted_e = 0;
    if (!ea && !eb) begin
      trace.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      trace.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    end else begin
      pr = ea ? pa : pb;
      for (int k = 0; k < S; k++) begin
        act.push_back(mk(0, 1, ea, eb, 0, 0, 0)); prf.push_back(0); reff.push_back(0);
      end
      for (int k = 0; k < PS * PP; k++) begin
        p = ((k + 1) % PP) == 0;
        act.push_back(mk(0, 1, ea, eb, p && ea, p && eb, 0)); prf.push_back(1); reff.push_back(0);
      end
      if (steps == 0) begin
        act.push_back(mk(0, 1, ea, eb, 0, 0, 0)); prf.push_back(1); reff.push_back(0);
      end else begin
        for (int k = 0; k < steps * pr; k++) begin
          act.push_back(mk(0, 1, ea, eb, ea && ((k + 1) % pa == 0), eb && ((k + 1) % pb == 0), 0));
          prf.push_back(1);
          reff.push_back(((k + 1) % pr) == 0);
        end
      end
      bi = INF;
`ifdef GRAD_INLET_BUBBLE_ABORT_EN
      if (bub_at >= 0 && ((bub_val[0] && ea) || (bub_val[1] && eb)))
        for (int j = bub_at + 2; j < act.size(); j++)
          if (prf[j]) begin bi = j; break; end
`endif
      a = (abort_at >= 0 && abort_at < act.size()) ? abort_at : INF;
      n = (a < INF || bi < INF) ? ((a < bi) ? a : bi) + 1 : act.size();
      fault_e = (bi < INF) && (bi <= a);
      aborted_e = fault_e || (abort_at >= 0 && abort_at < n + S);
      for (int j = 0; j < n; j++) begin
        trace.push_back(act[j]);
        if (reff[j]) steps_e++;
      end
      for (int j = 0; j < S; j++) trace.push_back(mk(0, 1, 0, 0, 0, 0, 0));
      trace.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      trace.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    end

    cmd_valid = 1'b1;
    cmd_period_a = PW'(pa);
    cmd_period_b = PW'(pb);
    cmd_steps = CW'(steps);
    abort = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_period_a = PW'($urandom);
    cmd_period_b = PW'($urandom);
    cmd_steps = CW'($urandom);
    for (int i = 0; i < trace.size(); i++) begin
      abort = (i == abort_at);
`ifdef GRAD_INLET_BUBBLE_ABORT_EN
      bubble_det = (bub_at >= 0 && i >= bub_at) ? bub_val : 2'b00;
`endif
      @(negedge clk);
      check($sformatf("%s outputs cycle %0d", name, i), 32'(sample()), 32'(trace[i]));
      if (trace[i].done) begin
        check({name, " steps_done"}, 32'(steps_done), 32'(steps_e));
        check({name, " aborted"}, 32'(aborted), 32'(aborted_e));
        check({name, " fault"}, 32'(fault), 32'(fault_e));
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
`ifdef GRAD_INLET_BUBBLE_ABORT_EN
    bubble_det = 2'b00;
`endif
  endtask

  initial begin
    int pa, pb, st, ab;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'(sample()), 32'(mk(1, 0, 0, 0, 0, 0, 0)));
    check("reset steps_done", 32'(steps_done), 32'd0);
    check("reset aborted", 32'(aborted), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd("normal", 3, 5, 4, -1, -1, 2'b00);
    run_cmd("a_off", 0, 1, 3, -1, -1, 2'b00);
    run_cmd("both_off", 0, 0, 7, -1, -1, 2'b00);
    run_cmd("abort_run", 3, 5, 10, S + PS * PP + 5, -1, 2'b00);
    run_cmd("abort_open", 2, 2, 3, 0, -1, 2'b00);
    run_cmd("abort_close", 1, 0, 2, S + PS * PP + 3, -1, 2'b00);
    run_cmd("zero_steps", 2, 3, 0, -1, -1, 2'b00);

    cmd_valid = 1'b1; cmd_period_a = 3; cmd_period_b = 5; cmd_steps = 4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (S + PS * PP + 2) @(posedge clk);
    #1;
    check("pre-reset step_a", 32'(step_a), 32'd1);
    rst = 1'b1;
    #1;
    check("async reset outputs", 32'(sample()), 32'(mk(1, 0, 0, 0, 0, 0, 0)));
    check("async reset steps_done", 32'(steps_done), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmd("after_reset", 2, 1, 3, -1, -1, 2'b00);

`ifdef GRAD_INLET_BUBBLE_ABORT_EN
    run_cmd("bubble_a", 3, 5, 4, -1, S, 2'b01);
    run_cmd("bubble_b_off", 3, 0, 4, -1, 0, 2'b10);
`endif

    for (int r = 0; r < 25; r++) begin
      pa = $urandom_range(0, 4);
      pb = $urandom_range(0, 4);
      st = $urandom_range(0, 5);
      ab = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 40));
      if (pa == 0 && pb == 0) ab = -1;
      run_cmd($sformatf("rand%0d", r), pa, pb, st, ab, -1, 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gradient_inlet_sequencer.md
Name: gradient_inlet_sequencer

Overview:
- Digital controller upstream of the 2-inlet/9-outlet serpentine gradient generator.
- Drives the two inlet syringe pumps (step pulses) and inlet isolation valves that feed the generator's two inlet ports.
- Runs a command-driven open → prime → run → close sequence; the per-pump step periods set the inlet flow ratio and therefore the gradient shape.
- Sits between the host command interface and the pump/valve driver pins.

Parameters:
- PERIOD_W, 16, width of the per-pump step period (clock cycles per step).
- COUNT_W, 24, width of the run step count and the step counters.
- VALVE_SETTLE, 1000, cycles spent in OPEN and in CLOSE; ≥1.
- PRIME_STEPS, 256, step pulses issued to each enabled pump during PRIME; 0 skips PRIME.
- PRIME_PERIOD, 64, step period used during PRIME; ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_period_a  in  PERIOD_W  pump A step period; 0 disables pump A.
- cmd_period_b  in  PERIOD_W  pump B step period; 0 disables pump B.
- cmd_steps  in  COUNT_W  RUN length, counted on the reference pump.
- abort  in  1  level; ends the sequence early.
- valve_a, valve_b  out  1  inlet valve open.
- step_a, step_b  out  1  one-cycle pump step pulses.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- aborted  out  1  valid with done; sequence was ended by abort or fault.
- steps_done  out  COUNT_W  reference-pump RUN steps issued; holds its value until the next accept.
- fault  out  1  sticky bubble fault (see Optional Feature).

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0 except cmd_ready=1; all counters cleared.
- Accept: cmd_valid && cmd_ready at a clock edge.
  - Capture period_a, period_b and steps.
  - Clear steps_done and aborted.
  - If both periods are 0: stay in IDLE and pulse done on the next cycle; valves never move.
  - Otherwise: next state OPEN.
- Reference pump: A if period_a ≠ 0, else B.
- States:
  - OPEN: valve_x = 1 for each enabled pump; held for exactly VALVE_SETTLE cycles, then PRIME.
  - PRIME: each enabled pump steps every PRIME_PERIOD cycles. The first pulse comes PRIME_PERIOD cycles after entry. Exit to RUN after the reference pump's PRIME_STEPS-th pulse.
  - RUN: each enabled pump steps every cmd_period_x cycles. The first pulse comes period cycles after entry; period 1 means a pulse every cycle. steps_done increments on each reference pulse. Exit to CLOSE on the cycle the count reaches cmd_steps. If cmd_steps = 0, RUN lasts 1 cycle with no pulses.
  - CLOSE: valves 0, no pulses; held for VALVE_SETTLE cycles, then IDLE with done = 1 on the first IDLE cycle.
- Dividers: each divider loads period−1 on state entry and pulses at 0, then reloads. Dividers of disabled pumps never pulse.
- Abort: sampled in OPEN, PRIME or RUN.
  - Next state is CLOSE; no step pulse in the cycle after abort is seen.
  - aborted = 1 is presented with done.
  - Abort in CLOSE lets CLOSE complete normally, with aborted set.
  - Abort in IDLE is ignored, including when it coincides with an accept.
- steps_done saturates at cmd_steps and never wraps.

Optional Feature:
- Macro: GRAD_INLET_BUBBLE_ABORT_EN.
- Defined:
  - Adds input bubble_det[1:0] (bit0 = inlet A, bit1 = inlet B), each through a 2-FF synchroniser.
  - A synchronised high on an enabled inlet during PRIME or RUN acts as abort and sets fault.
  - fault clears only on the next accept or on reset.
- Undefined: no bubble_det port; fault tied to 0.

Decomposition:
- Package grad_inlet_pkg:
  - state enum (IDLE, OPEN, PRIME, RUN, CLOSE);
  - default widths/constants.
- Sub-module step_divider: period load, enable, one-cycle pulse out. Instantiated twice.

Test Plan (VALVE_SETTLE=4, PRIME_STEPS=2, PRIME_PERIOD=2):
1. Normal run with period_a=3, period_b=5, steps=4:
   - valves high 4 cycles before the first step;
   - PRIME gives 2 pulses each at a 2-cycle spacing;
   - RUN gives step_a every 3 cycles ×4 and step_b every 5;
   - done with aborted=0 and steps_done=4.
2. Pump A disabled (period_a=0, period_b=1, steps=3):
   - valve_a stays 0;
   - B is the reference and steps on 3 consecutive cycles;
   - steps_done=3.
3. Both periods 0: done pulses 1 cycle after accept; busy and valves stay 0.
4. Abort on the 2nd RUN step_a with steps=10:
   - no further pulses;
   - CLOSE lasts 4 cycles;
   - done with aborted=1 and steps_done=2.
5. Reset asserted mid-RUN: in the same cycle valves=0, busy=0, cmd_ready=1; a new command is then accepted normally.
6. With GRAD_INLET_BUBBLE_ABORT_EN, bubble_det=2'b01 during PRIME:
   - abort path taken; fault=1 until the next accept;
   - bubble_det=2'b10 with pump B disabled is ignored.
